// File: rtl/chip_test_sequencer.sv
// Session controller for the chip-checker testers: launches one selected tester,
// waits for Done or a timeout, holds the verdict for display and keeps pass/fail tallies.
module chip_test_sequencer #(
  parameter int NUM_CHIPS      = 8,
  parameter int SEL_W          = 3,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int SETTLE_CYCLES  = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 Ack,
  input  logic [SEL_W-1:0]     Sel,
  input  logic [NUM_CHIPS-1:0] chip_done,
  input  logic [NUM_CHIPS-1:0] chip_rslt,
  output logic [NUM_CHIPS-1:0] chip_run,
  output logic [NUM_CHIPS-1:0] chip_disp_rslt,
  output logic [SEL_W-1:0]     active_sel,
  output logic                 busy,
  output logic                 result_valid,
  output logic                 pass,
  output logic                 timeout,
  output logic                 bad_sel,
  output logic [7:0]           pass_count,
  output logic [7:0]           fail_count
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int STL_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [STL_W-1:0] STL_LAST = STL_W'(SETTLE_CYCLES - 1);
  localparam logic [SEL_W:0]   SEL_LIMIT = (SEL_W + 1)'(NUM_CHIPS);
  localparam logic [3:0]       REL_LAST = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_SETTLE,
    S_SHOW,
    S_RELEASE
  } state_t;

  state_t             state;
  logic               start_q;
  logic               ack_q;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [STL_W-1:0]   stl_cnt;
  logic [3:0]         rel_cnt;

  logic               start_rise;
  logic               ack_rise;
  logic               sel_ok;
  logic [NUM_CHIPS-1:0] launch_oh;
  logic [NUM_CHIPS-1:0] sel_oh;
  logic               done_sel;
  logic               rslt_sel;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Out-of-range selects shift the one-hot mask to zero, so no tester is ever touched.
  assign start_rise = Start & ~start_q;
  assign ack_rise   = Ack & ~ack_q;
  assign sel_ok     = {1'b0, Sel} < SEL_LIMIT;
  assign launch_oh  = NUM_CHIPS'(1) << Sel;
  assign sel_oh     = NUM_CHIPS'(1) << active_sel;
  assign done_sel   = |(chip_done & sel_oh);
  assign rslt_sel   = |(chip_rslt & sel_oh);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state          <= S_IDLE;
      start_q        <= 1'b1;
      ack_q          <= 1'b1;
      tmo_cnt        <= '0;
      stl_cnt        <= '0;
      rel_cnt        <= '0;
      chip_run       <= '0;
      chip_disp_rslt <= '0;
      active_sel     <= '0;
      busy           <= 1'b0;
      result_valid   <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      bad_sel        <= 1'b0;
      pass_count     <= '0;
      fail_count     <= '0;
    end else begin
      start_q <= Start;
      ack_q   <= Ack;
      case (state)
        S_IDLE: begin
          if (start_rise) begin
            active_sel   <= Sel;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            bad_sel      <= 1'b0;
            if (sel_ok) begin
              chip_run <= launch_oh;
              busy     <= 1'b1;
              state    <= S_LAUNCH;
            end else begin
              bad_sel      <= 1'b1;
              pass         <= 1'b0;
              fail_count   <= sat_inc(fail_count);
              result_valid <= 1'b1;
              state        <= S_SHOW;
            end
          end
        end

        S_LAUNCH: begin
          chip_run <= '0;
          tmo_cnt  <= '0;
          state    <= S_WAIT;
        end

        S_WAIT: begin
          if (done_sel) begin
            stl_cnt <= '0;
            state   <= S_SETTLE;
          end else if (tmo_cnt == TMO_LAST) begin
            timeout      <= 1'b1;
            pass         <= 1'b0;
            fail_count   <= sat_inc(fail_count);
            result_valid <= 1'b1;
            state        <= S_SHOW;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        // RSLT is sampled once the settle window closes, even if Done dropped meanwhile.
        S_SETTLE: begin
          if (stl_cnt == STL_LAST) begin
            pass         <= rslt_sel;
            result_valid <= 1'b1;
            if (rslt_sel) pass_count <= sat_inc(pass_count);
            else          fail_count <= sat_inc(fail_count);
            state        <= S_SHOW;
          end else begin
            stl_cnt <= stl_cnt + 1'b1;
          end
        end

        S_SHOW: begin
          if (ack_rise) begin
            if (bad_sel) begin
              state <= S_IDLE;
            end else begin
              chip_disp_rslt <= sel_oh;
              rel_cnt        <= '0;
              state          <= S_RELEASE;
            end
          end
        end

        // A tester stuck in Test never drops Done, so the hold is bounded.
        S_RELEASE: begin
          if (!done_sel || rel_cnt == REL_LAST) begin
            chip_disp_rslt <= '0;
            busy           <= 1'b0;
            state          <= S_IDLE;
          end else begin
            rel_cnt <= rel_cnt + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
